// File: rtl/param_frame_pkg.sv
// Shared constants, state type and byte selection for the parameter frame serializer.
package param_frame_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         FRAME_LEN = 6;
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  // Index 5 (and any unused code) yields the XOR checksum of the four payload bytes.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [7:0] w,
                                            input logic [7:0] x,
                                            input logic [7:0] y,
                                            input logic [7:0] z);
    case (idx)
      3'd0:    return FRAME_HDR;
      3'd1:    return w;
      3'd2:    return x;
      3'd3:    return y;
      3'd4:    return z;
      default: return w ^ x ^ y ^ z;
    endcase
  endfunction

endpackage

// File: rtl/param_frame_tx.sv
// Serializes the W/X/Y/Z parameters as a 6-byte frame on a valid/ready stream.
// Define PARAM_FRAME_DUMP_EN to print every accepted byte and each frame completion.
module param_frame_tx
  import param_frame_pkg::*;
#(
  parameter int         W = 9,
  parameter int         X = 9,
  parameter logic [7:0] Y = 8'd9,
  parameter int         Z = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] frame_count
);

  localparam logic [7:0] W8 = W[7:0];
  localparam logic [7:0] X8 = X[7:0];
  localparam logic [7:0] Z8 = Z[7:0];

  state_t     state;
  logic [2:0] idx;
  logic [2:0] next_idx;

  assign next_idx = idx + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_last    <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SEND;
            idx       <= 3'd0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= FRAME_HDR;
            out_last  <= 1'b0;
          end
        end
        SEND: begin
          if (out_valid && out_ready) begin
            if (idx == LAST_IDX) begin
              frame_count <= frame_count + 8'd1;
              idx         <= 3'd0;
              out_last    <= 1'b0;
              // A start on the closing handshake chains the next frame with no bubble.
              if (start) begin
                out_data <= FRAME_HDR;
              end else begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_data  <= 8'h00;
              end
            end else begin
              idx      <= next_idx;
              out_data <= frame_byte(next_idx, W8, X8, Y, Z8);
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PARAM_FRAME_DUMP_EN
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      $display("param_frame_tx byte=%0d data=%h last=%b", idx, out_data, out_last);
      if (out_last)
        $display("param_frame_tx frame_count=%0d", frame_count + 8'd1);
    end
  end
`endif

endmodule
